baud_tick_gen: RTL

//  Parametrised bit-rate tick generator for the serial (RS-232) transmit and receive paths.

---
 rtl/baud_pkg.sv | 16 +
 rtl/baud_tick_gen_prescaler.sv | 78 +++++++
 rtl/baud_tick_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared widths, divisor types and the divisor clamp for the baud tick generator.
package baud_pkg;

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned FRAC_W  = 8;
    localparam int unsigned MIN_DIV = 2;

    typedef logic [DIV_W-1:0]  div_t;
    typedef logic [FRAC_W-1:0] frac_t;

    // Divisors below MIN_DIV would give a zero-length or single-cycle period.
    function automatic div_t clamp_div(input div_t val);
        return (val < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : val;
    endfunction

endpackage

// File: rtl/baud_tick_gen_prescaler.sv
// Clock prescaler: counts divisor cycles per oversample tick and raises term_c on the last one.
// With BAUD_FRAC_DIV_EN a fractional accumulator stretches selected periods by one cycle.
module baud_prescaler
    import baud_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  enable,
    input  logic  restart,
    input  logic  clear,
    input  div_t  divisor,
`ifdef BAUD_FRAC_DIV_EN
    input  frac_t frac,
`endif
    output logic  term_c
);

    div_t pre_q;
    div_t pre_d;
    div_t last_c;

`ifdef BAUD_FRAC_DIV_EN
    frac_t           acc_q;
    frac_t           acc_d;
    logic            stretch_q;
    logic            stretch_d;
    logic [FRAC_W:0] sum_c;

    // A carry out of the accumulator lengthens the following period by one cycle.
    assign last_c = stretch_q ? divisor : divisor - DIV_W'(1);
    assign sum_c  = {1'b0, acc_q} + {1'b0, frac};

    always_comb begin
        acc_d     = acc_q;
        stretch_d = stretch_q;
        if (restart) begin
            acc_d     = '0;
            stretch_d = 1'b0;
        end else if (term_c) begin
            acc_d     = sum_c[FRAC_W-1:0];
            stretch_d = sum_c[FRAC_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            stretch_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            stretch_q <= stretch_d;
        end
    end
`else
    assign last_c = divisor - DIV_W'(1);
`endif

    assign term_c = enable & ~restart & (pre_q == last_c);

    // clear realigns the phase whenever the divisor changes outside a period boundary.
    always_comb begin
        pre_d = pre_q;
        if (restart || clear || term_c) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = pre_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Bit-rate tick generator: oversample ticks, mid-bit and end-of-bit flags, bit-aligned divisor updates.
// Optional fractional divisor selected by macro BAUD_FRAC_DIV_EN.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV = 27,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          restart,
    input  logic                          div_wr,
    input  div_t                          div_val,
`ifdef BAUD_FRAC_DIV_EN
    input  frac_t                         div_frac,
`endif
    output logic                          div_busy,
    output logic                          sample_tick,
    output logic                          end_half_time,
    output logic                          end_bit_time,
    output logic [$clog2(OVERSAMPLE)-1:0] sample_idx
);

    localparam int unsigned       SUB_W    = $clog2(OVERSAMPLE);
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0]  SUB_HALF = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam div_t              RST_DIV  = DIV_W'(DEFAULT_DIV);

    div_t             div_q, div_d;
    div_t             shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             sample_tick_q, sample_tick_d;
    logic             end_half_q, end_half_d;
    logic             end_bit_q, end_bit_d;

    logic             term_c;
    logic             bit_end_c;
    logic             apply_c;
    logic             load_c;
    div_t             wr_div_c;

`ifdef BAUD_FRAC_DIV_EN
    frac_t            frac_q, frac_d;
    frac_t            frac_shadow_q, frac_shadow_d;
`endif

    assign wr_div_c  = clamp_div(div_val);
    assign bit_end_c = term_c & (sub_q == SUB_LAST);
    assign apply_c   = bit_end_c | restart | ~enable;
    assign load_c    = apply_c & (pending_q | div_wr);

    baud_prescaler u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .restart (restart),
        .clear   (load_c & ~enable),
        .divisor (div_q),
`ifdef BAUD_FRAC_DIV_EN
        .frac    (frac_q),
`endif
        .term_c  (term_c)
    );

    // Sub index, divisor shadow/apply and tick output next-state.
    always_comb begin
        sub_d         = sub_q;
        div_d         = div_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        sample_tick_d = term_c;
        end_half_d    = term_c & (sub_q == SUB_HALF);
        end_bit_d     = bit_end_c;
`ifdef BAUD_FRAC_DIV_EN
        frac_d        = frac_q;
        frac_shadow_d = frac_shadow_q;
`endif

        if (restart) begin
            sub_d = '0;
        end else if (term_c) begin
            sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
        end

        // A write landing on an apply edge goes straight to the live divisor.
        if (load_c) begin
            div_d     = div_wr ? wr_div_c : shadow_q;
            pending_d = 1'b0;
`ifdef BAUD_FRAC_DIV_EN
            frac_d    = div_wr ? div_frac : frac_shadow_q;
`endif
        end else if (div_wr) begin
            shadow_d      = wr_div_c;
            pending_d     = 1'b1;
`ifdef BAUD_FRAC_DIV_EN
            frac_shadow_d = div_frac;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q         <= '0;
            div_q         <= RST_DIV;
            shadow_q      <= RST_DIV;
            pending_q     <= 1'b0;
            sample_tick_q <= 1'b0;
            end_half_q    <= 1'b0;
            end_bit_q     <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
            frac_q        <= '0;
            frac_shadow_q <= '0;
`endif
        end else begin
            sub_q         <= sub_d;
            div_q         <= div_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            sample_tick_q <= sample_tick_d;
            end_half_q    <= end_half_d;
            end_bit_q     <= end_bit_d;
`ifdef BAUD_FRAC_DIV_EN
            frac_q        <= frac_d;
            frac_shadow_q <= frac_shadow_d;
`endif
        end
    end

    assign div_busy      = pending_q;
    assign sample_tick   = sample_tick_q;
    assign end_half_time = end_half_q;
    assign end_bit_time  = end_bit_q;
    assign sample_idx    = sub_q;

endmodule
